ysyx_23060136_ifu_bht: RTL and testbench

Branch history table with update controller. Holds 2-bit saturating direction counters indexed by PC and answers the IFU's same-cycle taken/not-taken lookup. Consumes the resolve-time update request (pc, predict-true, predict-false) from the EXU branch stage through a one-stage write pipeline with forwarding. Runs a reset-time sweep FSM that initialises every entry before predictions are enabled.

---
 rtl/ysyx_23060136_bht_pkg.sv | 11 +
 rtl/ysyx_23060136_bht_sat_ctr.sv | 12 +
 rtl/ysyx_23060136_ifu_bht.sv | 80 ++++++++
 tb/tb_ysyx_23060136_ifu_bht.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060136_bht_pkg.sv
// ysyx_23060136_bht_pkg: shared types and constants for the branch history table.
`ifndef ysyx_23060136_BITS_W
`define ysyx_23060136_BITS_W 32
`endif

package ysyx_23060136_bht_pkg;
  typedef logic [1:0] bht_ctr_t;
  typedef enum logic {SWEEP, READY} bht_state_e;
  localparam bht_ctr_t BHT_CTR_INIT = 2'b01;
  localparam bht_ctr_t BHT_CTR_MAX = 2'b11;
endpackage

// File: rtl/ysyx_23060136_bht_sat_ctr.sv
// ysyx_23060136_bht_sat_ctr: 2-bit saturating counter next-state function.
module ysyx_23060136_bht_sat_ctr
  import ysyx_23060136_bht_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_nxt
);
  always_comb
    ctr_nxt = taken ? (ctr == BHT_CTR_MAX ? ctr : ctr + 2'd1)
                    : (ctr == 2'b00 ? ctr : ctr - 2'd1);
endmodule

// File: rtl/ysyx_23060136_ifu_bht.sv
// ysyx_23060136_ifu_bht: 2-bit BHT with reset sweep, forwarding update pipeline and perf counters.
// Define YSYX_23060136_BHT_BYPASS_EN to forward the pending write into the prediction path.
module ysyx_23060136_ifu_bht
  import ysyx_23060136_bht_pkg::*;
#(
  parameter int BHT_IDX_W = 6,
  parameter int BITS_W = `ysyx_23060136_BITS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BITS_W-1:0] IFU_pc,
  output logic              BHT_ready,
  output logic              BHT_pre_take,
  input  logic [BITS_W-1:0] BHT_pc,
  input  logic              BHT_pre_true,
  input  logic              BHT_pre_false,
  input  logic              EXU_pre_take,
  output logic [BITS_W-1:0] BHT_cnt_true,
  output logic [BITS_W-1:0] BHT_cnt_false
);
  localparam int ENTRIES = 1 << BHT_IDX_W;
  localparam logic [BHT_IDX_W-1:0] IDX_LAST = '1;

  bht_state_e state;
  bht_ctr_t tbl [ENTRIES];
  bht_ctr_t pend_ctr, src_ctr, nxt_ctr, look_ctr;
  logic [BHT_IDX_W-1:0] init_idx, pend_idx, upd_idx, look_idx;
  logic pend_vld, ready, upd_vld, taken;
  logic unused_pc_bits;

  assign unused_pc_bits = ^{IFU_pc[BITS_W-1:BHT_IDX_W+2], IFU_pc[1:0],
                            BHT_pc[BITS_W-1:BHT_IDX_W+2], BHT_pc[1:0]};

  assign ready = state == READY;
  assign BHT_ready = ready;
  assign upd_idx = BHT_pc[BHT_IDX_W+1:2];
  assign look_idx = IFU_pc[BHT_IDX_W+1:2];
  assign upd_vld = ready & (BHT_pre_true ^ BHT_pre_false);
  assign taken = EXU_pre_take ^ BHT_pre_false;
  // Forward the not-yet-written counter so back-to-back updates accumulate.
  assign src_ctr = (pend_vld && pend_idx == upd_idx) ? pend_ctr : tbl[upd_idx];
`ifdef YSYX_23060136_BHT_BYPASS_EN
  assign look_ctr = (pend_vld && pend_idx == look_idx) ? pend_ctr : tbl[look_idx];
`else
  assign look_ctr = tbl[look_idx];
`endif
  assign BHT_pre_take = ready & look_ctr[1];

  ysyx_23060136_bht_sat_ctr u_sat_ctr (
    .ctr     (src_ctr),
    .taken   (taken),
    .ctr_nxt (nxt_ctr)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= SWEEP;
      init_idx <= '0;
      pend_vld <= 1'b0;
      pend_idx <= '0;
      pend_ctr <= BHT_CTR_INIT;
      BHT_cnt_true <= '0;
      BHT_cnt_false <= '0;
    end else begin
      if (state == SWEEP) begin
        init_idx <= init_idx + 1'b1;
        if (init_idx == IDX_LAST) state <= READY;
      end
      pend_vld <= upd_vld;
      pend_idx <= upd_idx;
      pend_ctr <= nxt_ctr;
      if (upd_vld && BHT_pre_true && ~&BHT_cnt_true) BHT_cnt_true <= BHT_cnt_true + 1'b1;
      if (upd_vld && BHT_pre_false && ~&BHT_cnt_false) BHT_cnt_false <= BHT_cnt_false + 1'b1;
    end

  // Table has no reset: the sweep owns initialisation, pending writes only occur in READY.
  always_ff @(posedge clk)
    if (state == SWEEP) tbl[init_idx] <= BHT_CTR_INIT;
    else if (pend_vld) tbl[pend_idx] <= pend_ctr;
endmodule

// File: tb/tb_ysyx_23060136_ifu_bht.sv
// tb_ysyx_23060136_ifu_bht: directed and random checks of the BHT against a per-entry model.
module tb_ysyx_23060136_ifu_bht;
`ifdef YSYX_23060136_BHT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] IFU_pc = '0, BHT_pc = '0;
  logic BHT_pre_true = 1'b0, BHT_pre_false = 1'b0, EXU_pre_take = 1'b0;
  logic BHT_ready, BHT_pre_take;
  logic [31:0] BHT_cnt_true, BHT_cnt_false;

  int passed = 0, total = 0, fails = 0;
  int cur [64];
  int lag [64];
  int m_true, m_false, edges;
  bit m_ready;

  always #5 clk = ~clk;

  ysyx_23060136_ifu_bht #(.BHT_IDX_W(6), .BITS_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IFU_pc        (IFU_pc),
    .BHT_ready     (BHT_ready),
    .BHT_pre_take  (BHT_pre_take),
    .BHT_pc        (BHT_pc),
    .BHT_pre_true  (BHT_pre_true),
    .BHT_pre_false (BHT_pre_false),
    .EXU_pre_take  (EXU_pre_take),
    .BHT_cnt_true  (BHT_cnt_true),
    .BHT_cnt_false (BHT_cnt_false)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_pt(input logic [31:0] ipc);
    int i = int'(ipc[7:2]);
    int v = BYP ? cur[i] : lag[i];
    return m_ready && v >= 2;
  endfunction

  task automatic model_reset();
    foreach (cur[i]) begin
      cur[i] = 1;
      lag[i] = 1;
    end
    m_true = 0;
    m_false = 0;
    edges = 0;
    m_ready = 1'b0;
  endtask

  task automatic drive(input logic [31:0] ipc, input logic [31:0] bpc,
                       input logic pt, input logic pf, input logic ept);
    IFU_pc = ipc;
    BHT_pc = bpc;
    BHT_pre_true = pt;
    BHT_pre_false = pf;
    EXU_pre_take = ept;
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_ready"}, BHT_ready, m_ready);
    chk({tag, "_pt"}, BHT_pre_take, exp_pt(IFU_pc));
    chk({tag, "_ctrue"}, BHT_cnt_true, m_true);
    chk({tag, "_cfalse"}, BHT_cnt_false, m_false);
  endtask

  // Lag holds the state one update behind: what the table alone shows without bypass.
  task automatic tick();
    int i;
    @(posedge clk);
    lag = cur;
    if (m_ready && (BHT_pre_true ^ BHT_pre_false)) begin
      i = int'(BHT_pc[7:2]);
      if (EXU_pre_take ^ BHT_pre_false) cur[i] = cur[i] == 3 ? 3 : cur[i] + 1;
      else cur[i] = cur[i] == 0 ? 0 : cur[i] - 1;
      if (BHT_pre_true) m_true++;
      else m_false++;
    end
    edges++;
    m_ready = edges >= 64;
    @(negedge clk);
  endtask

  task automatic cycle(input string tag, input logic [31:0] ipc, input logic [31:0] bpc,
                       input logic pt, input logic pf, input logic ept);
    drive(ipc, bpc, pt, pf, ept);
    check_model(tag);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    chk("rst_ready", BHT_ready, 0);
    chk("rst_pt", BHT_pre_take, 0);
    chk("rst_ctrue", BHT_cnt_true, 0);
    chk("rst_cfalse", BHT_cnt_false, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic sweep_check(input int upto);
    for (int k = 0; k <= upto; k++) begin
      if (k < 64) drive($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
      else drive($urandom, $urandom, 1'b0, 1'b0, 1'b0);
      chk("sweep_ready", BHT_ready, k >= 64);
      if (k < 64) chk("sweep_pt", BHT_pre_take, 0);
      check_model("sweep");
      if (k < upto) tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ipc, bpc;
    logic [1:0] pp;
    model_reset();
    @(negedge clk);
    do_reset();
    sweep_check(64);
    // taken training of entry 4
    cycle("train0", 32'h8000_0010, 32'h8000_0010, 1'b0, 1'b1, 1'b0);
    cycle("train1", 32'h8000_0010, 32'h8000_0010, 1'b0, 1'b1, 1'b0);
    cycle("train2", 32'h8000_0010, '0, 1'b0, 1'b0, 1'b0);
    drive(32'h8000_0010, '0, 1'b0, 1'b0, 1'b0);
    chk("train_pt", BHT_pre_take, 1);
    chk("train_cfalse", BHT_cnt_false, 2);
    tick();
    // illegal updates that would decrement if accepted
    cycle("ill0", 32'h8000_0010, 32'h8000_0010, 1'b1, 1'b1, 1'b1);
    cycle("ill1", 32'h8000_0010, 32'h8000_0010, 1'b1, 1'b1, 1'b1);
    cycle("ill2", 32'h8000_0010, '0, 1'b0, 1'b0, 1'b0);
    drive(32'h8000_0010, '0, 1'b0, 1'b0, 1'b0);
    chk("ill_pt", BHT_pre_take, 1);
    chk("ill_ctrue", BHT_cnt_true, 0);
    chk("ill_cfalse", BHT_cnt_false, 2);
    tick();
    // saturation at 00 through an aliased PC
    do_reset();
    sweep_check(64);
    repeat (3) cycle("sat", 32'h8000_0010, 32'h8000_0110, 1'b1, 1'b0, 1'b0);
    repeat (2) cycle("sat_idle", 32'h8000_0010, '0, 1'b0, 1'b0, 1'b0);
    drive(32'h8000_0010, '0, 1'b0, 1'b0, 1'b0);
    chk("sat_pt", BHT_pre_take, 0);
    chk("sat_ctrue", BHT_cnt_true, 3);
    tick();
    cycle("nowrap0", 32'h8000_0010, 32'h8000_0010, 1'b0, 1'b1, 1'b0);
    cycle("nowrap1", 32'h8000_0010, '0, 1'b0, 1'b0, 1'b0);
    drive(32'h8000_0010, '0, 1'b0, 1'b0, 1'b0);
    chk("nowrap_pt", BHT_pre_take, 0);
    tick();
    // bypass visibility
    do_reset();
    sweep_check(64);
    cycle("byp0", 32'h8000_0010, 32'h8000_0010, 1'b0, 1'b1, 1'b0);
    drive(32'h8000_0010, '0, 1'b0, 1'b0, 1'b0);
    chk("byp_n1", BHT_pre_take, BYP);
    check_model("byp1");
    tick();
    drive(32'h8000_0010, '0, 1'b0, 1'b0, 1'b0);
    chk("byp_n2", BHT_pre_take, 1);
    tick();
    // random traffic on a small set of aliasing indices
    for (int n = 0; n < 400; n++) begin
      ipc = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
      bpc = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
      pp = 2'($urandom);
      cycle("rand", ipc, bpc, pp[0], pp[1], 1'($urandom));
    end
    // reset in the middle of a sweep
    do_reset();
    sweep_check(20);
    do_reset();
    sweep_check(64);
    // reset in READY with a pending write outstanding
    cycle("pend", 32'h8000_0014, 32'h8000_0014, 1'b0, 1'b1, 1'b0);
    do_reset();
    sweep_check(64);
    for (int i = 0; i < 64; i++) begin
      drive(32'h8000_0000 | 32'(i << 2), '0, 1'b0, 1'b0, 1'b0);
      chk("post_rst_entry", BHT_pre_take, 0);
      tick();
    end
    cycle("post0", 32'h8000_0014, 32'h8000_0014, 1'b0, 1'b1, 1'b0);
    cycle("post1", 32'h8000_0014, '0, 1'b0, 1'b0, 1'b0);
    drive(32'h8000_0014, '0, 1'b0, 1'b0, 1'b0);
    chk("post_pt", BHT_pre_take, 1);
    chk("post_cfalse", BHT_cnt_false, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
